// File: rtl/arb_pkg.sv
// Shared types for the data-memory arbiter.
//   arb_state_e : access sequencer states
//   arb_mid_t   : master identifier (0 = load/store path, 1 = debug/boot loader)
//   ARB_CNT_W   : width of the memory-latency counter (MEM_LAT up to 15)
package arb_pkg;

  localparam int ARB_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  typedef logic arb_mid_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin selector.
//   req_i[1:0]   : pending requests (bit n = master n)
//   last_owner_i : master that owned the previous access
//   lock_i       : master-1 lock; masks master 0 while master 1 was last owner
//   winner_o     : selected master (meaningful only with valid_o)
//   valid_o      : at least one eligible request
module rr_pick2
  import arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_owner_i,
  input  logic       lock_i,
  output logic       winner_o,
  output logic       valid_o
);

  logic [1:0] eff;
  arb_mid_t   pick;

  always_comb begin
    eff = req_i;
    // Lock only holds the bus once master 1 already owns it.
    if (lock_i && last_owner_i) begin
      eff[0] = 1'b0;
    end
    valid_o = |eff;
    pick    = 1'b0;
    if (eff == 2'b11) begin
      pick = ~last_owner_i;
    end else if (eff[1]) begin
      pick = 1'b1;
    end
    winner_o = pick;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter and access sequencer for the single-port data memory.
// Each access runs IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP -> IDLE.
// Optional feature macro: ARB_LOCK_EN adds i_m1_lock (master-1 bus lock).
// Ports:
//   i_clk, i_rst                 : clock, async active-high reset
//   i_mN_req/wren/addr/wdata/bmask : master N access request and payload
//   i_m1_lock                    : bus lock (ARB_LOCK_EN only)
//   o_mN_gnt, o_mN_done          : one-cycle grant / completion pulses
//   o_mN_rdata                   : per-master read data, held until next read
//   o_mem_req/wren/addr/wdata/bmask, i_mem_rdata : memory port
//   o_busy                       : sequencer not in IDLE
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_m0_req,
  input  logic              i_m0_wren,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [31:0]       i_m0_wdata,
  input  logic [3:0]        i_m0_bmask,
  input  logic              i_m1_req,
  input  logic              i_m1_wren,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [31:0]       i_m1_wdata,
  input  logic [3:0]        i_m1_bmask,
`ifdef ARB_LOCK_EN
  input  logic              i_m1_lock,
`endif
  output logic              o_m0_gnt,
  output logic              o_m1_gnt,
  output logic              o_m0_done,
  output logic              o_m1_done,
  output logic [31:0]       o_m0_rdata,
  output logic [31:0]       o_m1_rdata,
  output logic              o_mem_req,
  output logic              o_mem_wren,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_busy
);

  arb_state_e           state_q, state_d;
  logic [ARB_CNT_W-1:0] cnt_q, cnt_d;
  arb_mid_t             last_q, last_d;
  arb_mid_t             owner_q, owner_d;
  logic                 wren_q, wren_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           bmask_q, bmask_d;
  logic [31:0]          rd0_q, rd0_d;
  logic [31:0]          rd1_q, rd1_d;

  logic lock;
  logic pick_win;
  logic pick_vld;

`ifdef ARB_LOCK_EN
  assign lock = i_m1_lock;
`else
  assign lock = 1'b0;
`endif

  rr_pick2 u_pick (
    .req_i        ({i_m1_req, i_m0_req}),
    .last_owner_i (last_q),
    .lock_i       (lock),
    .winner_o     (pick_win),
    .valid_o      (pick_vld)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      bmask_q <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      bmask_q <= bmask_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    owner_d    = owner_q;
    wren_d     = wren_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    bmask_d    = bmask_q;
    rd0_d      = rd0_q;
    rd1_d      = rd1_q;
    o_m0_gnt   = 1'b0;
    o_m1_gnt   = 1'b0;
    o_m0_done  = 1'b0;
    o_m1_done  = 1'b0;
    o_mem_req  = 1'b0;
    o_mem_wren = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = ISSUE;
          owner_d = pick_win;
          last_d  = pick_win;
          if (pick_win == 1'b0) begin
            wren_d  = i_m0_wren;
            addr_d  = i_m0_addr;
            wdata_d = i_m0_wdata;
            bmask_d = i_m0_bmask;
          end else begin
            wren_d  = i_m1_wren;
            addr_d  = i_m1_addr;
            wdata_d = i_m1_wdata;
            bmask_d = i_m1_bmask;
          end
        end
      end
      ISSUE: begin
        o_mem_req  = 1'b1;
        o_mem_wren = wren_q;
        o_m0_gnt   = (owner_q == 1'b0);
        o_m1_gnt   = (owner_q == 1'b1);
        cnt_d      = ARB_CNT_W'(MEM_LAT);
        state_d    = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - ARB_CNT_W'(1);
        // Count value 1 marks the final latency cycle: read data is valid now.
        if (cnt_q == ARB_CNT_W'(1)) begin
          state_d = RESP;
          if (!wren_q) begin
            if (owner_q == 1'b0) begin
              rd0_d = i_mem_rdata;
            end else begin
              rd1_d = i_mem_rdata;
            end
          end
        end
      end
      RESP: begin
        o_m0_done = (owner_q == 1'b0);
        o_m1_done = (owner_q == 1'b1);
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_bmask = bmask_q;
  assign o_m0_rdata  = rd0_q;
  assign o_m1_rdata  = rd1_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-timestamp reference model
// (arbitration cycle t0 -> grant t0+1, sample t0+1+L, done t0+2+L, idle t0+3+L)
// checks the MEM_LAT=1 instance every cycle; a MEM_LAT=3 instance shares the
// inputs and is checked in the latency scenario.
module tb_mem_arbiter;

  localparam int L = 1;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m0_req, m0_wren, m1_req, m1_wren, lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata;
  logic [3:0]  m0_bmask, m1_bmask;

  logic        m0_gnt, m1_gnt, m0_done, m1_done, mem_req, mem_wren, busy;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_bmask;

  logic        m0_gnt_3, m1_gnt_3, m0_done_3, m1_done_3, mem_req_3, mem_wren_3, busy_3;
  logic [31:0] m0_rdata_3, m1_rdata_3, mem_addr_3, mem_wdata_3;
  logic [3:0]  mem_bmask_3;

  mem_arbiter #(.MEM_LAT(L), .ADDR_W(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(m0_req), .i_m0_wren(m0_wren), .i_m0_addr(m0_addr),
    .i_m0_wdata(m0_wdata), .i_m0_bmask(m0_bmask),
    .i_m1_req(m1_req), .i_m1_wren(m1_wren), .i_m1_addr(m1_addr),
    .i_m1_wdata(m1_wdata), .i_m1_bmask(m1_bmask),
`ifdef ARB_LOCK_EN
    .i_m1_lock(lock),
`endif
    .o_m0_gnt(m0_gnt), .o_m1_gnt(m1_gnt), .o_m0_done(m0_done), .o_m1_done(m1_done),
    .o_m0_rdata(m0_rdata), .o_m1_rdata(m1_rdata),
    .o_mem_req(mem_req), .o_mem_wren(mem_wren), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask),
    .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  mem_arbiter #(.MEM_LAT(3), .ADDR_W(32)) dut3 (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(m0_req), .i_m0_wren(m0_wren), .i_m0_addr(m0_addr),
    .i_m0_wdata(m0_wdata), .i_m0_bmask(m0_bmask),
    .i_m1_req(m1_req), .i_m1_wren(m1_wren), .i_m1_addr(m1_addr),
    .i_m1_wdata(m1_wdata), .i_m1_bmask(m1_bmask),
`ifdef ARB_LOCK_EN
    .i_m1_lock(lock),
`endif
    .o_m0_gnt(m0_gnt_3), .o_m1_gnt(m1_gnt_3), .o_m0_done(m0_done_3), .o_m1_done(m1_done_3),
    .o_m0_rdata(m0_rdata_3), .o_m1_rdata(m1_rdata_3),
    .o_mem_req(mem_req_3), .o_mem_wren(mem_wren_3), .o_mem_addr(mem_addr_3),
    .o_mem_wdata(mem_wdata_3), .o_mem_bmask(mem_bmask_3),
    .i_mem_rdata(mem_rdata), .o_busy(busy_3)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state
  int          cyc, m_start;
  bit          m_active, m_last, m_owner, m_wren;
  logic [31:0] m_addr, m_wdata, m_rd0, m_rd1;
  logic [3:0]  m_bmask;
  logic        e_gnt0, e_gnt1, e_done0, e_done1, e_req, e_wren, e_busy;

  task automatic model_reset();
    cyc = 0; m_start = 0; m_active = 0; m_last = 1; m_owner = 0; m_wren = 0;
    m_addr = '0; m_wdata = '0; m_bmask = '0; m_rd0 = '0; m_rd1 = '0;
  endtask

  task automatic model_eval();
    int ph;
    bit act;
    ph  = cyc - m_start;
    act = m_active && (ph <= 2 + L);
    e_busy  = act && (ph >= 1);
    e_req   = act && (ph == 1);
    e_wren  = e_req && m_wren;
    e_gnt0  = e_req && !m_owner;
    e_gnt1  = e_req && m_owner;
    e_done0 = act && (ph == 2 + L) && !m_owner;
    e_done1 = act && (ph == 2 + L) && m_owner;
  endtask

  // Consumes the inputs present during the current cycle.
  task automatic model_advance();
    int ph;
    bit act, r0, r1, w;
    ph  = cyc - m_start;
    act = m_active && (ph <= 2 + L);
    if (act) begin
      if (ph == 1 + L && !m_wren) begin
        if (m_owner) m_rd1 = mem_rdata;
        else         m_rd0 = mem_rdata;
      end
    end else begin
      r0 = m0_req && !(lock && m_last);
      r1 = m1_req;
      m_active = r0 || r1;
      if (r0 || r1) begin
        w = (r0 && r1) ? !m_last : r1;
        m_start = cyc; m_owner = w; m_last = w;
        m_wren  = w ? m1_wren  : m0_wren;
        m_addr  = w ? m1_addr  : m0_addr;
        m_wdata = w ? m1_wdata : m0_wdata;
        m_bmask = w ? m1_bmask : m0_bmask;
      end
    end
    cyc++;
  endtask

  function automatic logic [6:0] ctrl_act();
    return {m0_gnt, m1_gnt, m0_done, m1_done, mem_req, mem_wren, busy};
  endfunction
  function automatic logic [6:0] ctrl_exp();
    return {e_gnt0, e_gnt1, e_done0, e_done1, e_req, e_wren, e_busy};
  endfunction
  function automatic logic [131:0] data_act();
    return {mem_addr, mem_wdata, mem_bmask, m0_rdata, m1_rdata};
  endfunction
  function automatic logic [131:0] data_exp();
    return {m_addr, m_wdata, m_bmask, m_rd0, m_rd1};
  endfunction

  task automatic clr_inputs();
    m0_req = 0; m0_wren = 0; m0_addr = '0; m0_wdata = '0; m0_bmask = '0;
    m1_req = 0; m1_wren = 0; m1_addr = '0; m1_wdata = '0; m1_bmask = '0;
    lock = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    model_advance();
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      @(negedge clk);
      model_eval();
      model_advance();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; clr_inputs(); mem_rdata = '0;
    #1 rst = 1'b1;
    #2;
    n_vec++;
    if (ctrl_act() !== 7'd0) begin
      n_err++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl_act(), 7'd0);
    end
    n_vec++;
    if (data_act() !== 132'd0) begin
      n_err++; $display("FAIL reset_data got=%h exp=0", data_act());
    end
    n_vec++;
    if ({m0_gnt_3, m1_gnt_3, m0_done_3, m1_done_3, mem_req_3, mem_wren_3, busy_3, m0_rdata_3} !== 39'd0) begin
      n_err++; $display("FAIL reset_lat3 got busy=%b rdata=%h exp=0", busy_3, m0_rdata_3);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    model_advance();
    @(negedge clk);
    model_eval();
    n_vec++;
    if (ctrl_act() !== ctrl_exp()) begin
      n_err++; $display("FAIL post_reset_idle got=%b exp=%b", ctrl_act(), ctrl_exp());
    end
    model_advance();
  endtask

  task automatic test_m0_read();
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      model_eval();
      n_vec++;
      if (ctrl_act() !== ctrl_exp()) begin
        n_err++; $display("FAIL m0_read_ctrl k=%0d got=%b exp=%b", k, ctrl_act(), ctrl_exp());
      end
      if (k == 1) begin
        n_vec++;
        if ({m0_gnt, m1_gnt, mem_req, mem_wren, mem_addr} !== {4'b1010, 32'h10}) begin
          n_err++; $display("FAIL m0_read_issue got=%b/%h exp=1010/00000010",
                            {m0_gnt, m1_gnt, mem_req, mem_wren}, mem_addr);
        end
      end
      if (k == 2) begin
        n_vec++;
        if (m0_done !== 1'b0) begin
          n_err++; $display("FAIL m0_read_early_done got=%b exp=0", m0_done);
        end
      end
      if (k == 3) begin
        n_vec++;
        if ({m0_done, m0_rdata} !== {1'b1, 32'hDEADBEEF}) begin
          n_err++; $display("FAIL m0_read_done got=%b/%h exp=1/deadbeef", m0_done, m0_rdata);
        end
      end
      if (k == 4) begin
        n_vec++;
        if (busy !== 1'b0) begin
          n_err++; $display("FAIL m0_read_idle got=%b exp=0", busy);
        end
      end
      if (k == 0) begin
        m0_req = 1; m0_wren = 0; m0_addr = 32'h10; m0_wdata = 32'h0; m0_bmask = 4'hF;
        mem_rdata = 32'hDEADBEEF;
      end
      if (k == 1) m0_req = 0;
      model_advance();
    end
  endtask

  task automatic test_alternate();
    int gcyc[$];
    bit gm[$];
    clr_inputs();
    apply_reset();
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      model_eval();
      n_vec++;
      if (ctrl_act() !== ctrl_exp()) begin
        n_err++; $display("FAIL alt_ctrl k=%0d got=%b exp=%b", k, ctrl_act(), ctrl_exp());
      end
      if (m0_gnt || m1_gnt) begin
        gcyc.push_back(k);
        gm.push_back(m1_gnt);
      end
      if (k == 0) begin
        m0_req = 1; m0_addr = 32'h100; m0_bmask = 4'hF;
        m1_req = 1; m1_addr = 32'h200; m1_bmask = 4'hF;
      end
      mem_rdata = $urandom;
      model_advance();
    end
    n_vec++;
    if (gm.size() < 4) begin
      n_err++; $display("FAIL alt_count got=%0d exp>=4", gm.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (gm[i] !== (i % 2 == 1)) begin
          n_err++; $display("FAIL alt_owner idx=%0d got=%0d exp=%0d", i, gm[i], i % 2);
        end
        if (i > 0) begin
          n_vec++;
          if (gcyc[i] - gcyc[i-1] !== L + 3) begin
            n_err++; $display("FAIL alt_spacing idx=%0d got=%0d exp=%0d", i, gcyc[i] - gcyc[i-1], L + 3);
          end
        end
      end
    end
    clr_inputs();
    drain(8);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      model_eval();
      n_vec++;
      if (ctrl_act() !== ctrl_exp()) begin
        n_err++; $display("FAIL rand_ctrl i=%0d got=%b exp=%b", i, ctrl_act(), ctrl_exp());
      end
      n_vec++;
      if (data_act() !== data_exp()) begin
        n_err++; $display("FAIL rand_data i=%0d got=%h exp=%h", i, data_act(), data_exp());
      end
      if (e_gnt0 || !m0_req) begin
        m0_req = ($urandom_range(0, 1) == 1);
        if (m0_req) begin
          m0_wren = 1'($urandom_range(0, 1)); m0_addr = $urandom;
          m0_wdata = $urandom; m0_bmask = 4'($urandom);
        end
      end
      if (e_gnt1 || !m1_req) begin
        m1_req = ($urandom_range(0, 1) == 1);
        if (m1_req) begin
          m1_wren = 1'($urandom_range(0, 1)); m1_addr = $urandom;
          m1_wdata = $urandom; m1_bmask = 4'($urandom);
        end
      end
      mem_rdata = $urandom;
      model_advance();
    end
    clr_inputs();
    drain(8);
  endtask

  task automatic test_m1_write();
    logic [31:0] rd1_before;
    rd1_before = m_rd1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      model_eval();
      n_vec++;
      if (ctrl_act() !== ctrl_exp()) begin
        n_err++; $display("FAIL m1_wr_ctrl k=%0d got=%b exp=%b", k, ctrl_act(), ctrl_exp());
      end
      if (k == 1) begin
        n_vec++;
        if ({m1_gnt, m0_gnt, mem_req, mem_wren, mem_addr, mem_wdata, mem_bmask} !==
            {4'b1011, 32'h20, 32'h12345678, 4'hF}) begin
          n_err++; $display("FAIL m1_wr_issue got=%b/%h/%h/%h exp=1011/00000020/12345678/f",
                            {m1_gnt, m0_gnt, mem_req, mem_wren}, mem_addr, mem_wdata, mem_bmask);
        end
      end
      if (k == 2) begin
        n_vec++;
        if (m1_done !== 1'b0) begin
          n_err++; $display("FAIL m1_wr_early_done got=%b exp=0", m1_done);
        end
      end
      if (k == 3) begin
        n_vec++;
        if ({m1_done, m1_rdata} !== {1'b1, rd1_before}) begin
          n_err++; $display("FAIL m1_wr_done got=%b/%h exp=1/%h", m1_done, m1_rdata, rd1_before);
        end
      end
      if (k == 0) begin
        m1_req = 1; m1_wren = 1; m1_addr = 32'h20; m1_wdata = 32'h12345678; m1_bmask = 4'hF;
      end
      if (k == 1) m1_req = 0;
      mem_rdata = $urandom;
      model_advance();
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      model_eval();
      n_vec++;
      if (ctrl_act() !== ctrl_exp()) begin
        n_err++; $display("FAIL rstmid_ctrl k=%0d got=%b exp=%b", k, ctrl_act(), ctrl_exp());
      end
      if (k == 0) begin
        m0_req = 1; m0_wren = 0; m0_addr = 32'h30; m0_bmask = 4'h3;
        mem_rdata = 32'hA5A50001;
      end
      if (k == 1) m0_req = 0;
      if (k < 2) model_advance();
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (ctrl_act() !== 7'd0) begin
      n_err++; $display("FAIL rstmid_async_ctrl got=%b exp=0000000", ctrl_act());
    end
    n_vec++;
    if (data_act() !== 132'd0) begin
      n_err++; $display("FAIL rstmid_async_data got=%h exp=0", data_act());
    end
    repeat (2) begin
      @(negedge clk);
      n_vec++;
      if (ctrl_act() !== 7'd0) begin
        n_err++; $display("FAIL rstmid_hold got=%b exp=0000000", ctrl_act());
      end
    end
    rst = 1'b0;
    model_reset();
    model_advance();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      model_eval();
      n_vec++;
      if ({ctrl_act(), m0_done} !== {ctrl_exp(), 1'b0}) begin
        n_err++; $display("FAIL rstmid_no_done k=%0d got=%b exp=%b", k, ctrl_act(), ctrl_exp());
      end
      model_advance();
    end
    test_m0_read();
  endtask

  task automatic test_lat3();
    logic [31:0] samp;
    samp = '0;
    clr_inputs();
    apply_reset();
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      model_eval();
      n_vec++;
      if (ctrl_act() !== ctrl_exp()) begin
        n_err++; $display("FAIL lat3_ref_ctrl k=%0d got=%b exp=%b", k, ctrl_act(), ctrl_exp());
      end
      if (k == 1) begin
        n_vec++;
        if ({m0_gnt_3, mem_req_3, mem_addr_3} !== {2'b11, 32'h44}) begin
          n_err++; $display("FAIL lat3_issue got=%b/%h exp=11/00000044", {m0_gnt_3, mem_req_3}, mem_addr_3);
        end
      end
      if (k == 4) begin
        n_vec++;
        if (m0_done_3 !== 1'b0) begin
          n_err++; $display("FAIL lat3_early_done got=%b exp=0", m0_done_3);
        end
      end
      if (k == 5) begin
        n_vec++;
        if ({m0_done_3, busy_3, m0_rdata_3} !== {2'b11, samp}) begin
          n_err++; $display("FAIL lat3_done got=%b/%h exp=11/%h", {m0_done_3, busy_3}, m0_rdata_3, samp);
        end
      end
      if (k == 6) begin
        n_vec++;
        if (busy_3 !== 1'b0) begin
          n_err++; $display("FAIL lat3_idle got=%b exp=0", busy_3);
        end
      end
      if (k == 0) begin
        m0_req = 1; m0_wren = 0; m0_addr = 32'h44; m0_bmask = 4'hF;
      end
      if (k == 1) m0_req = 0;
      mem_rdata = $urandom;
      if (k == 4) samp = mem_rdata;
      model_advance();
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    bit gm[$];
    clr_inputs();
    apply_reset();
    for (int k = 0; k < 40 && gm.size() < 4; k++) begin
      @(negedge clk);
      model_eval();
      n_vec++;
      if (ctrl_act() !== ctrl_exp()) begin
        n_err++; $display("FAIL lock_ctrl k=%0d got=%b exp=%b", k, ctrl_act(), ctrl_exp());
      end
      if (m0_gnt || m1_gnt) gm.push_back(m1_gnt);
      if (k == 0) begin
        lock = 1;
        m0_req = 1; m0_addr = 32'h300; m0_bmask = 4'hF;
        m1_req = 1; m1_addr = 32'h400; m1_bmask = 4'hF;
      end
      if (gm.size() == 3) lock = 0;
      mem_rdata = $urandom;
      model_advance();
    end
    n_vec++;
    if (gm.size() < 4) begin
      n_err++; $display("FAIL lock_count got=%0d exp=4", gm.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (gm[i] !== (i < 3)) begin
          n_err++; $display("FAIL lock_owner idx=%0d got=%0d exp=%0d", i, gm[i], (i < 3));
        end
      end
    end
    clr_inputs();
    drain(8);
  endtask
`endif

  initial begin
    test_reset();
    test_m0_read();
    test_alternate();
    test_random();
    test_m1_write();
    test_reset_mid();
    test_lat3();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
